num_smul_arbiter: RTL and testbench
===================================

NUM_SMUL_ARBITER -- requirements
Module: num_smul_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 2, number of requesters (2..8); LEFT_WIDTH, default 32, left operand width; RIGHT_WIDTH, default 32, right operand width; OUT_WIDTH, default 64, product width.
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  sole clock; all state updates on rising edge.
 reset  in  1  asynchronous, active-high reset.
 req_go  in  NUM_REQ  per-requester go; held high until matching req_done.
 req_left  in  NUM_REQ*LEFT_WIDTH  packed signed left operands; slice i belongs to requester i.
 req_right  in  NUM_REQ*RIGHT_WIDTH  packed signed right operands.
 req_out  out  NUM_REQ*OUT_WIDTH  packed per-requester result registers.
 req_done  out  NUM_REQ  one-cycle completion pulse per requester.
 mul_left  out  LEFT_WIDTH  operand to shared num_smul.
 mul_right  out  RIGHT_WIDTH  operand to shared num_smul.
 mul_go  out  1  go to shared num_smul.
 mul_out  in  OUT_WIDTH  product from shared num_smul.
 mul_done  in  1  done from shared num_smul.
 busy  out  1  high whenever state is not IDLE.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-004 IDLE: if any req_go bit is high, SHALL grant one requester by round-robin, capture its req_left/req_right slices into operand registers, record the grant index, and go to BUSY at the next edge; otherwise SHALL stay in IDLE.
REQ-005 Round-robin order SHALL start at the index after the last granted index, wrapping NUM_REQ-1 to 0; after reset the last granted index SHALL be NUM_REQ-1, so requester 0 has top priority.
REQ-006 BUSY: mul_go SHALL be 1; mul_left/mul_right SHALL be driven from the operand registers and SHALL remain stable for the whole BUSY interval.
REQ-007 BUSY with mul_done=1: SHALL write mul_out into slice [grant] of req_out and go to DONE; BUSY with mul_done=0: SHALL stay in BUSY with no timeout.
REQ-008 DONE: req_done[grant] SHALL be 1 for exactly this cycle, all other req_done bits 0; mul_go SHALL be 0, which clears the multiplier's done pipeline.
REQ-009 DONE: SHALL arbitrate per REQ-005 among requesters other than the current grantee; if one is found, SHALL capture its operands and go directly to BUSY; otherwise SHALL go to IDLE.
REQ-010 Requester i SHALL deassert req_go in the cycle after req_done[i]; if it keeps req_go high, the block SHALL treat that as a new request, granted no earlier than IDLE.
REQ-011 Each req_out slice SHALL hold its value until that requester's next completion; other slices SHALL never change on a completion.
REQ-012 Operands SHALL be sampled only at grant; changes on req_left/req_right after grant SHALL NOT affect the result.
REQ-013 A req_go bit that drops before grant SHALL NOT be served; a requester's req_go dropping while it is granted SHALL NOT abort the operation, and req_done SHALL still pulse.
REQ-014 With the 2-cycle num_smul, latency SHALL be 4 cycles from the first req_go-high edge in IDLE to the req_done cycle; back-to-back throughput SHALL be one product per 4 cycles.
REQ-015 busy SHALL be 1 in BUSY and DONE and 0 in IDLE; mul_go SHALL be 0 in IDLE and DONE.
REQ-016 mul_out SHALL be passed through unmodified; width, sign and truncation are owned by num_smul.

Reset
REQ-017 While reset=1, asynchronously and without a clock edge: state=IDLE; last grant=NUM_REQ-1; operand registers, req_out, req_done, mul_go and busy SHALL be 0.
REQ-018 Reset asserted in BUSY or DONE SHALL abandon the operation with no req_done pulse; after release, the first grant SHALL follow the post-reset priority.

Verification (NUM_REQ=2, LEFT_WIDTH=RIGHT_WIDTH=8, OUT_WIDTH=16, real num_smul attached)
REQ-019 Single op: req_go=01, left0=3, right0=-5 -> mul_go high 3 cycles, req_done=01 on the 4th cycle, req_out[15:0]=16'hFFF1, req_out[31:16] unchanged.
REQ-020 Contention: req_go=11 from IDLE after reset -> requester 0 served first, then requester 1 via DONE->BUSY; req_done pulses 4 cycles apart; mul_go low exactly one cycle between the two operations.
REQ-021 Fairness: req_go=11 held with requesters re-raising go after each done -> grants alternate 0,1,0,1 and neither requester is served twice in a row.
REQ-022 Operand stability: change left0 from 3 to 7 one cycle after grant -> result stays 16'hFFF1.
REQ-023 Reset mid-op: assert reset in the second BUSY cycle -> outputs are 0 immediately with no clock edge, no req_done; after release, req_go=10 is served with a normal 4-cycle latency.
REQ-024 Extremes: left0=-128, right0=-128 -> req_out[15:0]=16'h4000; left0=127, right0=-128 -> 16'hC080.

Source files
------------

// File: rtl/num_smul_arbiter.sv
// num_smul_arbiter: shares one signed multiplier (num_smul) among NUM_REQ
// requesters. A round-robin arbiter picks a requester, latches its operands,
// holds mul_go high until the multiplier reports done, stores the product in
// that requester's result slot and pulses its req_done for one cycle.
module num_smul_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int LEFT_WIDTH  = 32,
  parameter int RIGHT_WIDTH = 32,
  parameter int OUT_WIDTH   = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_go,
  input  logic [NUM_REQ*LEFT_WIDTH-1:0]  req_left,
  input  logic [NUM_REQ*RIGHT_WIDTH-1:0] req_right,
  output logic [NUM_REQ*OUT_WIDTH-1:0]   req_out,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [LEFT_WIDTH-1:0]          mul_left,
  output logic [RIGHT_WIDTH-1:0]         mul_right,
  output logic                           mul_go,
  input  logic [OUT_WIDTH-1:0]           mul_out,
  input  logic                           mul_done,
  output logic                           busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         state_q;
  // grant_q doubles as the "last granted" pointer for round-robin.
  logic [IW-1:0]                  grant_q;
  logic [LEFT_WIDTH-1:0]          left_q;
  logic [RIGHT_WIDTH-1:0]         right_q;
  logic [NUM_REQ*OUT_WIDTH-1:0]   req_out_q;
  logic [NUM_REQ-1:0]             req_done_q;
  logic                           mul_go_q;
  logic                           busy_q;

  logic                           pick_valid;
  logic [IW-1:0]                  pick_idx;
  logic [IW-1:0]                  cand_idx;
  logic [LEFT_WIDTH-1:0]          pick_left;
  logic [RIGHT_WIDTH-1:0]         pick_right;

  // Round-robin search starting just after the last grant; in DONE the
  // current grantee is skipped so a held req_go is only re-served from IDLE
  // or after another requester has had its turn.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IW'((int'(grant_q) + k) % NUM_REQ);
      if (!pick_valid && req_go[cand_idx] &&
          !(state_q == S_DONE && cand_idx == grant_q)) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Operand slices of the requester that would be granted this cycle.
  always_comb begin
    pick_left  = req_left[int'(pick_idx)*LEFT_WIDTH +: LEFT_WIDTH];
    pick_right = req_right[int'(pick_idx)*RIGHT_WIDTH +: RIGHT_WIDTH];
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= IW'(NUM_REQ - 1);
      left_q     <= '0;
      right_q    <= '0;
      req_out_q  <= '0;
      req_done_q <= '0;
      mul_go_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      req_done_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            left_q   <= pick_left;
            right_q  <= pick_right;
            grant_q  <= pick_idx;
            state_q  <= S_BUSY;
            mul_go_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_BUSY: begin
          if (mul_done) begin
            req_out_q[int'(grant_q)*OUT_WIDTH +: OUT_WIDTH] <= mul_out;
            req_done_q[grant_q] <= 1'b1;
            state_q  <= S_DONE;
            mul_go_q <= 1'b0;
          end
        end
        S_DONE: begin
          // mul_go stays low here for one cycle so the multiplier flushes its done pipeline.
          if (pick_valid) begin
            left_q   <= pick_left;
            right_q  <= pick_right;
            grant_q  <= pick_idx;
            state_q  <= S_BUSY;
            mul_go_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mul_go_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_out   = req_out_q;
  assign req_done  = req_done_q;
  assign mul_left  = left_q;
  assign mul_right = right_q;
  assign mul_go    = mul_go_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_num_smul_arbiter.sv
// Directed bench for num_smul_arbiter with a 2-cycle signed multiplier
// model attached (NUM_REQ=2, 8x8 -> 16 bit). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_num_smul_arbiter;

  localparam int N  = 2;
  localparam int LW = 8;
  localparam int RW = 8;
  localparam int OW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_go;
  logic [N*LW-1:0]   req_left;
  logic [N*RW-1:0]   req_right;
  logic [N*OW-1:0]   req_out;
  logic [N-1:0]      req_done;
  logic [LW-1:0]     mul_left;
  logic [RW-1:0]     mul_right;
  logic              mul_go;
  logic [OW-1:0]     mul_out;
  logic              mul_done;
  logic              busy;

  int total = 0;
  int bad   = 0;

  num_smul_arbiter #(
    .NUM_REQ(N), .LEFT_WIDTH(LW), .RIGHT_WIDTH(RW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_go(req_go), .req_left(req_left), .req_right(req_right),
    .req_out(req_out), .req_done(req_done),
    .mul_left(mul_left), .mul_right(mul_right), .mul_go(mul_go),
    .mul_out(mul_out), .mul_done(mul_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: done two edges after go rises, cleared when go drops.
  logic          m_v1;
  logic          m_done;
  logic [OW-1:0] m_prod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v1   <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_v1   <= mul_go;
      m_done <= m_v1 & mul_go;
      m_prod <= OW'({{(OW-LW){mul_left[LW-1]}}, mul_left} *
                    {{(OW-RW){mul_right[RW-1]}}, mul_right});
    end
  end
  assign mul_out  = m_prod;
  assign mul_done = m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    req_go    = '0;
    req_left  = '0;
    req_right = '0;
    #2;
    check("rst_busy",   busy,     1'b0);
    check("rst_mul_go", mul_go,   1'b0);
    check("rst_done",   req_done, 2'b00);
    check("rst_out",    req_out,  32'h0);
    check("rst_left",   mul_left, 8'h00);
    cyc(1);
    reset = 1'b0;

    // Single op: 3 * -5 on requester 0.
    req_left[7:0]  = 8'd3;
    req_right[7:0] = 8'hFB;
    req_go         = 2'b01;
    cyc(1);
    check("s_go1",    mul_go,    1'b1);
    check("s_busy",   busy,      1'b1);
    check("s_left",   mul_left,  8'h03);
    check("s_right",  mul_right, 8'hFB);
    check("s_done1",  req_done,  2'b00);
    cyc(1);
    check("s_go2",    mul_go,    1'b1);
    cyc(1);
    check("s_go3",    mul_go,    1'b1);
    check("s_done3",  req_done,  2'b00);
    cyc(1);
    check("s_done4",  req_done,  2'b01);
    check("s_go4",    mul_go,    1'b0);
    check("s_out0",   req_out[15:0],  16'hFFF1);
    check("s_out1",   req_out[31:16], 16'h0000);
    req_go = 2'b00;
    cyc(1);
    check("s_idle_done", req_done, 2'b00);
    check("s_idle_busy", busy,     1'b0);

    // Extremes.
    req_left[7:0]  = 8'h80;
    req_right[7:0] = 8'h80;
    req_go         = 2'b01;
    cyc(4);
    check("x1_done", req_done,      2'b01);
    check("x1_out0", req_out[15:0], 16'h4000);
    req_go = 2'b00;
    cyc(1);
    req_left[7:0]  = 8'h7F;
    req_right[7:0] = 8'h80;
    req_go         = 2'b01;
    cyc(4);
    check("x2_done", req_done,      2'b01);
    check("x2_out0", req_out[15:0], 16'hC080);
    req_go = 2'b00;
    cyc(1);

    // Operand stability: left0 changes after grant.
    req_left[7:0]  = 8'd3;
    req_right[7:0] = 8'hFB;
    req_go         = 2'b01;
    cyc(1);
    req_left[7:0]  = 8'd7;
    cyc(1);
    check("st_left", mul_left, 8'h03);
    cyc(2);
    check("st_done", req_done,      2'b01);
    check("st_out0", req_out[15:0], 16'hFFF1);
    req_go = 2'b00;
    cyc(1);

    // Contention right after reset: requester 0 first, then 1.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("c_rst_out", req_out, 32'h0);
    req_left  = {8'hFE, 8'h05};
    req_right = {8'h09, 8'h06};
    req_go    = 2'b11;
    cyc(1);
    check("c_left0", mul_left, 8'h05);
    cyc(3);
    check("c_done0", req_done,      2'b01);
    check("c_gap",   mul_go,        1'b0);
    check("c_out0",  req_out[15:0], 16'h001E);
    req_go = 2'b10;
    cyc(1);
    check("c_go_b",  mul_go,   1'b1);
    check("c_left1", mul_left, 8'hFE);
    check("c_nodone", req_done, 2'b00);
    cyc(3);
    check("c_done1",  req_done,       2'b10);
    check("c_out1",   req_out[31:16], 16'hFFEE);
    check("c_out0_k", req_out[15:0],  16'h001E);
    req_go = 2'b00;
    cyc(1);
    check("c_idle", busy, 1'b0);

    // Fairness: both held high, grants alternate 0,1,0,1.
    req_go = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc(4);
      check($sformatf("f_done%0d", i), req_done, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_go = 2'b00;
    cyc(1);
    check("f_idle", busy, 1'b0);

    // Reset in the second BUSY cycle.
    req_left[7:0]  = 8'd3;
    req_right[7:0] = 8'hFB;
    req_go         = 2'b01;
    cyc(2);
    check("r_go", mul_go, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("r_busy", busy,     1'b0);
    check("r_mgo",  mul_go,   1'b0);
    check("r_done", req_done, 2'b00);
    check("r_out",  req_out,  32'h0);
    check("r_left", mul_left, 8'h00);
    req_go = 2'b00;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    check("r_nopulse", req_done, 2'b00);
    req_left[15:8]  = 8'd4;
    req_right[15:8] = 8'hFD;
    req_go          = 2'b10;
    cyc(3);
    check("r2_early", req_done, 2'b00);
    cyc(1);
    check("r2_done", req_done,       2'b10);
    check("r2_out1", req_out[31:16], 16'hFFF4);
    check("r2_out0", req_out[15:0],  16'h0000);
    req_go = 2'b00;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
